// File: rtl/word_assembly_ctrl_pkg.sv
// Shared types and constants for the byte-to-word assembly controller:
// FSM states, Len/OpSel encodings and register function-select codes.
package word_assembly_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FIRST = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] LEN_1    = 2'b00;
  localparam logic [1:0] LEN_2    = 2'b01;
  localparam logic [1:0] LEN_RSVD = 2'b10;
  localparam logic [1:0] LEN_4    = 2'b11;

  localparam logic [1:0] OP_DEC  = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LOADB = 3'b100;
  localparam logic [2:0] FS_SHB   = 3'b110;

  // Number of bytes to assemble for a Len code; 0 marks the reserved code.
  function automatic logic [2:0] len_to_count(input logic [1:0] len);
    logic [2:0] cnt;
    case (len)
      LEN_1:   cnt = 3'd1;
      LEN_2:   cnt = 3'd2;
      LEN_4:   cnt = 3'd4;
      default: cnt = 3'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/word_assembly_ctrl_timeout_counter.sv
// Idle-cycle counter: expired_o is high while the next counted cycle would
// be the TIMEOUT_CYCLES-th consecutive one without a byte.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/word_assembly_ctrl.sv
// Assembles 1/2/4 bytes MSB-first into an external 32-bit register and
// arbitrates a second requester's inc/dec/clear ops while idle.
module word_assembly_ctrl
  import word_assembly_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Len,
  input  logic        ByteValid,
  input  logic [7:0]  ByteIn,
  output logic        ByteReady,
  input  logic        OpReq,
  input  logic [1:0]  OpSel,
  output logic        OpAck,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [31:0] RegI,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic        error_q, error_d;

  logic        byte_ready_s;
  logic        op_ack_s;
  logic        reg_e_s;
  logic [2:0]  fun_sel_s;
  logic [31:0] reg_i_s;
  logic        tmo_clr_s;
  logic        tmo_en_s;
  logic        tmo_expired_s;

  timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .Clock     (Clock),
    .Reset     (Reset),
    .clr_i     (tmo_clr_s),
    .en_i      (tmo_en_s),
    .expired_o (tmo_expired_s)
  );

  // Next-state and combinational register/handshake outputs; all gated by Reset.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    error_d      = 1'b0;
    byte_ready_s = 1'b0;
    op_ack_s     = 1'b0;
    reg_e_s      = 1'b0;
    fun_sel_s    = FS_DEC;
    reg_i_s      = 32'd0;
    tmo_clr_s    = 1'b1;
    tmo_en_s     = 1'b0;
    if (Reset) begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (Len == LEN_RSVD) begin
              error_d = 1'b1;
            end else begin
              state_d = ST_FIRST;
              rem_d   = len_to_count(Len);
            end
          end else if (OpReq) begin
            op_ack_s = 1'b1;
            case (OpSel)
              OP_DEC: begin
                reg_e_s   = 1'b1;
                fun_sel_s = FS_DEC;
              end
              OP_INC: begin
                reg_e_s   = 1'b1;
                fun_sel_s = FS_INC;
              end
              OP_CLR: begin
                reg_e_s   = 1'b1;
                fun_sel_s = FS_CLR;
              end
              default: begin
                reg_e_s   = 1'b0;
                fun_sel_s = FS_DEC;
              end
            endcase
          end else begin
            op_ack_s = 1'b0;
          end
        end
        ST_FIRST, ST_SHIFT: begin
          byte_ready_s = 1'b1;
          tmo_clr_s    = ByteValid;
          tmo_en_s     = ~ByteValid;
          if (ByteValid) begin
            reg_e_s   = 1'b1;
            fun_sel_s = (state_q == ST_FIRST) ? FS_LOADB : FS_SHB;
            reg_i_s   = {24'd0, ByteIn};
            rem_d     = rem_q - 3'd1;
            state_d   = (rem_q == 3'd1) ? ST_DONE : ST_SHIFT;
          end else if (tmo_expired_s) begin
            // Abort: partial register contents stay as they are.
            state_d = ST_IDLE;
            error_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State, remaining byte count and registered error pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= 3'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      error_q <= error_d;
    end
  end

  assign ByteReady = byte_ready_s;
  assign OpAck     = op_ack_s;
  assign RegE      = reg_e_s;
  assign RegFunSel = fun_sel_s;
  assign RegI      = reg_i_s;
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_DONE);
  assign Error     = error_q;

endmodule

// File: tb/tb_word_assembly_ctrl.sv
// Bench for word_assembly_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction model.
module tb_word_assembly_ctrl;

  localparam int TO = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Len = 2'b00;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        ByteReady;
  logic        OpReq = 1'b0;
  logic [1:0]  OpSel = 2'b00;
  logic        OpAck;
  logic        RegE;
  logic [2:0]  RegFunSel;
  logic [31:0] RegI;
  logic        Busy;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;
  int          m_got    = 0;
  int          m_need   = 0;
  int          m_idle   = 0;
  logic [31:0] m_word   = 32'd0;
  logic [31:0] m_reg    = 32'd0;
  logic [31:0] ext_reg  = 32'd0;

  bit          n_err;
  logic        e_ack, e_rege;
  logic [2:0]  e_fs;
  logic [31:0] e_ri;

  always #5 Clock = ~Clock;

  word_assembly_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Len       (Len),
    .ByteValid (ByteValid),
    .ByteIn    (ByteIn),
    .ByteReady (ByteReady),
    .OpReq     (OpReq),
    .OpSel     (OpSel),
    .OpAck     (OpAck),
    .RegE      (RegE),
    .RegFunSel (RegFunSel),
    .RegI      (RegI),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare against the model mid-cycle, then advance model and external register.
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("rst_byteready", 32'(ByteReady), 32'd0);
      chk("rst_opack", 32'(OpAck), 32'd0);
      chk("rst_rege", 32'(RegE), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_error", 32'(Error), 32'd0);
      chk("rst_reg", ext_reg, m_reg);
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
    end else begin
      e_ack  = 1'b0;
      e_rege = 1'b0;
      e_fs   = 3'd0;
      e_ri   = 32'd0;
      if (m_active && ByteValid) begin
        e_rege = 1'b1;
        e_fs   = (m_got == 0) ? 3'd4 : 3'd6;
        e_ri   = {24'd0, ByteIn};
      end else if (!m_active && !m_done && !Start && OpReq) begin
        e_ack = 1'b1;
        if (OpSel != 2'b10) begin
          e_rege = 1'b1;
          e_fs   = {1'b0, OpSel};
        end
      end
      chk("byteready", 32'(ByteReady), 32'(m_active));
      chk("opack", 32'(OpAck), 32'(e_ack));
      chk("rege", 32'(RegE), 32'(e_rege));
      chk("funsel", 32'(RegFunSel), 32'(e_fs));
      chk("regi", RegI, e_ri);
      chk("busy", 32'(Busy), 32'(m_active || m_done));
      chk("done", 32'(Done), 32'(m_done));
      chk("error", 32'(Error), 32'(m_err));
      chk("reg", ext_reg, m_reg);
      if (m_done) chk("word", ext_reg, m_word);

      // External 32-bit register driven by the DUT's command outputs.
      if (RegE) begin
        case (RegFunSel)
          3'b000:  ext_reg = ext_reg - 32'd1;
          3'b001:  ext_reg = ext_reg + 32'd1;
          3'b010:  ext_reg = RegI;
          3'b011:  ext_reg = 32'd0;
          3'b100:  ext_reg = {24'd0, RegI[7:0]};
          3'b110:  ext_reg = {ext_reg[23:0], RegI[7:0]};
          default: ext_reg = ext_reg;
        endcase
      end

      n_err = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_active) begin
        if (ByteValid) begin
          m_reg  = (m_got == 0) ? {24'd0, ByteIn} : {m_reg[23:0], ByteIn};
          m_word = (m_word * 32'd256) + {24'd0, ByteIn};
          m_got++;
          m_idle = 0;
          if (m_got == m_need) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_active = 1'b0;
            n_err    = 1'b1;
          end
        end
      end else if (Start) begin
        if (Len == 2'b10) begin
          n_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_got    = 0;
          m_idle   = 0;
          m_word   = 32'd0;
          m_need   = (Len == 2'b00) ? 1 : ((Len == 2'b01) ? 2 : 4);
        end
      end else if (OpReq) begin
        case (OpSel)
          2'b00:   m_reg = m_reg - 32'd1;
          2'b01:   m_reg = m_reg + 32'd1;
          2'b11:   m_reg = 32'd0;
          default: m_reg = m_reg;
        endcase
      end
      m_err = n_err;
    end
  end

  task automatic drive(input logic s, input logic [1:0] l, input logic bv,
                       input logic [7:0] b, input logic oq, input logic [1:0] os);
    Start = s; Len = l; ByteValid = bv; ByteIn = b; OpReq = oq; OpSel = os;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  int mode;

  initial begin
    #2;
    chk("por_busy", 32'(Busy), 32'd0);
    chk("por_opack", 32'(OpAck), 32'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    tick();

    // Four bytes back-to-back.
    drive(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hDE, 1'b0, 2'b00);
    chk("w4_fs0", 32'(RegFunSel), 32'd4); chk("w4_ri0", RegI, 32'h000000DE); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hAD, 1'b0, 2'b00); chk("w4_fs1", 32'(RegFunSel), 32'd6); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hBE, 1'b0, 2'b00); chk("w4_fs2", 32'(RegFunSel), 32'd6); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hEF, 1'b0, 2'b00); chk("w4_fs3", 32'(RegFunSel), 32'd6); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("w4_done", 32'(Done), 32'd1); chk("w4_word", ext_reg, 32'hDEADBEEF); tick();
    chk("w4_done_off", 32'(Done), 32'd0); chk("w4_busy_off", 32'(Busy), 32'd0);

    // Two bytes with a three-cycle gap.
    drive(1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'h12, 1'b0, 2'b00); chk("w2_fs0", 32'(RegFunSel), 32'd4); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
      chk("w2_gap_ready", 32'(ByteReady), 32'd1); chk("w2_gap_rege", 32'(RegE), 32'd0); tick();
    end
    drive(1'b0, 2'b00, 1'b1, 8'h34, 1'b0, 2'b00); chk("w2_fs1", 32'(RegFunSel), 32'd6); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("w2_done", 32'(Done), 32'd1); chk("w2_word", ext_reg, 32'h00001234); tick();
    chk("w2_single_done", 32'(Done), 32'd0);

    // Start beats OpReq; op granted after Done.
    drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 2'b01); chk("arb_noack", 32'(OpAck), 32'd0); tick();
    drive(1'b0, 2'b00, 1'b1, 8'h55, 1'b1, 2'b01); chk("arb_busy_noack", 32'(OpAck), 32'd0); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 2'b01); chk("arb_done_noack", 32'(OpAck), 32'd0); tick();
    chk("arb_ack", 32'(OpAck), 32'd1); chk("arb_fs", 32'(RegFunSel), 32'd1); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00); chk("arb_inc", ext_reg, 32'h00000056);

    // Timeout after one byte.
    drive(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'h01, 1'b0, 2'b00); tick();
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
      chk("tmo_wait_err", 32'(Error), 32'd0); chk("tmo_wait_busy", 32'(Busy), 32'd1); tick();
    end
    chk("tmo_err", 32'(Error), 32'd1); chk("tmo_idle", 32'(Busy), 32'd0);
    chk("tmo_nodone", 32'(Done), 32'd0); chk("tmo_partial", ext_reg, 32'h00000001); tick();
    chk("tmo_err_pulse", 32'(Error), 32'd0);

    // Reset mid-assembly, then a one-byte word.
    drive(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hDE, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hAD, 1'b0, 2'b00); tick();
    drive(1'b0, 2'b00, 1'b1, 8'hBE, 1'b1, 2'b01);
    Reset = 1'b0;
    #1;
    chk("arst_ready", 32'(ByteReady), 32'd0); chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_rege", 32'(RegE), 32'd0); chk("arst_opack", 32'(OpAck), 32'd0);
    chk("arst_done", 32'(Done), 32'd0); chk("arst_error", 32'(Error), 32'd0);
    tick(); tick();
    Reset = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00); chk("post_rst_err", 32'(Error), 32'd0); tick();
    drive(1'b0, 2'b00, 1'b1, 8'h7F, 1'b0, 2'b00); chk("post_rst_fs", 32'(RegFunSel), 32'd4); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("post_rst_done", 32'(Done), 32'd1); chk("post_rst_word", ext_reg, 32'h0000007F); tick();

    // Reserved Len and reserved OpSel.
    drive(1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 2'b00); chk("rsv_len_rege", 32'(RegE), 32'd0); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("rsv_len_err", 32'(Error), 32'd1); chk("rsv_len_idle", 32'(Busy), 32'd0); tick();
    chk("rsv_len_err_pulse", 32'(Error), 32'd0);
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 2'b10);
    chk("rsv_op_ack", 32'(OpAck), 32'd1); chk("rsv_op_rege", 32'(RegE), 32'd0); tick();
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00); chk("rsv_op_reg", ext_reg, 32'h0000007F); tick();

    // Randomized traffic; modes vary byte density to reach timeouts.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(2, 0);
      Start     = ($urandom_range(5, 0) == 0);
      Len       = 2'($urandom);
      ByteValid = (mode == 2) ? ($urandom_range(9, 0) < 2) : ($urandom_range(9, 0) < 7);
      ByteIn    = 8'($urandom);
      OpReq     = ($urandom_range(2, 0) == 0);
      OpSel     = 2'($urandom);
      Reset     = ($urandom_range(399, 0) != 0);
      tick();
    end
    Reset = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_assembly_ctrl.md
WORD_ASSEMBLY_CTRL -- requirements
Module: word_assembly_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max idle cycles waiting for a byte before abort.
REQ-002 SHALL have port Clock  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  in  1  begin word assembly (sampled in IDLE only).
REQ-005 SHALL have port Len  in  2  byte count: 00=1, 01=2, 11=4, 10=reserved.
REQ-006 SHALL have port ByteValid  in  1  byte source has data.
REQ-007 SHALL have port ByteIn  in  8  byte data, first byte = most significant.
REQ-008 SHALL have port ByteReady  out  1  controller accepts byte this cycle.
REQ-009 SHALL have port OpReq  in  1  second requester wants a register op.
REQ-010 SHALL have port OpSel  in  2  00=decrement, 01=increment, 11=clear, 10=reserved.
REQ-011 SHALL have port OpAck  out  1  op granted this cycle.
REQ-012 SHALL have ports RegE out 1, RegFunSel out 3, RegI out 32: enable, function select and data to the 32-bit register.
REQ-013 SHALL have ports Busy, Done, Error, each out 1: assembly active, word complete pulse, abort pulse.

Function
REQ-014 SHALL implement FSM states IDLE, FIRST, SHIFT, DONE.
REQ-015 IDLE: Start=1 with Len valid -> FIRST next cycle; latch Len into remaining-count register.
REQ-016 IDLE: Start=1 with Len=10 -> one-cycle Error pulse next cycle, stay IDLE, no register write.
REQ-017 Byte transfer SHALL occur only when ByteValid and ByteReady are both 1 in the same cycle; ByteReady=1 exactly in FIRST and SHIFT.
REQ-018 FIRST transfer: RegE=1, RegFunSel=100, RegI={24'b0,ByteIn} combinationally in that cycle; next state SHIFT, or DONE if Len=1 byte.
REQ-019 SHIFT transfer: RegE=1, RegFunSel=110, RegI={24'b0,ByteIn}; decrement remaining count; DONE after final byte.
REQ-020 DONE: Done=1 for exactly one cycle, then IDLE; register holds assembled word in the Done cycle.
REQ-021 Busy SHALL be 1 in FIRST, SHIFT and DONE, else 0.
REQ-022 Timeout counter SHALL clear on each transfer and on entry to FIRST, and increment each FIRST/SHIFT cycle without transfer.
REQ-023 Counter reaching TIMEOUT_CYCLES -> Error=1 for one cycle, return to IDLE; partial register contents left as-is.
REQ-024 Arbitration: in IDLE, Start has priority over OpReq; if Start=1, OpAck=0 and OpReq remains pending.
REQ-025 IDLE with Start=0, OpReq=1: OpAck=1 combinationally; RegE=1 with RegFunSel 000/001/011 for OpSel 00/01/11.
REQ-026 OpSel=10: OpAck=1, RegE=0 (acknowledged no-op).
REQ-027 OpReq outside IDLE: OpAck=0; requester holds OpReq until acked.
REQ-028 RegE=0 in every cycle not covered by REQ-018/019/025; RegFunSel=000 and RegI=0 whenever RegE=0.
REQ-029 Start, ByteValid outside their accepting states SHALL be ignored with no side effects.

Reset
REQ-030 Reset low SHALL force IDLE, counters 0, and ByteReady, OpAck, RegE, Busy, Done, Error to 0 immediately, regardless of Clock.
REQ-031 Reset asserted mid-assembly SHALL abort without Error or Done; the register is not written during reset.
REQ-032 After Reset deasserts, first Start SHALL be honoured on the next rising edge.

Structure
REQ-033 Shared package SHALL hold the state enum, Len codes, OpSel codes and FunSel constants (FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_LOADB=100, FS_SHB=110).
REQ-034 Timeout counter SHALL be a sub-module named timeout_counter (clear, count-enable, expired output, TIMEOUT_CYCLES parameter).

Verification
REQ-035 Start, Len=11, bytes 0xDE,0xAD,0xBE,0xEF back-to-back -> FunSel 100,110,110,110; Done next cycle; register 0xDEADBEEF.
REQ-036 Start, Len=01, bytes 0x12 then 3 idle cycles then 0x34 -> ByteReady held through gap; register 0x00001234; single Done.
REQ-037 Start and OpReq(OpSel=01) same IDLE cycle -> OpAck=0, assembly runs; OpAck=1, FunSel=001 in first IDLE cycle after Done.
REQ-038 TIMEOUT_CYCLES=4, Start Len=11, one byte then ByteValid=0 -> Error pulse on timeout, back to IDLE, no Done.
REQ-039 Reset low during SHIFT after 2 of 4 bytes -> all outputs 0 immediately; after release Start Len=00 byte 0x7F -> register 0x0000007F.
REQ-040 Start Len=10 -> Error pulse next cycle, RegE never asserted; OpReq OpSel=10 in IDLE -> OpAck=1, RegE=0.
